// File: rtl/flash_boot_sequencer.sv
// Boot-time copier: moves WORD_COUNT flash words into RAM through the flash controller's register
// port, then hands the port to the CPU. Define FLASH_BOOT_CHECKSUM_EN to verify a trailing sum word.
module flash_boot_sequencer #(
    parameter logic [23:0] FLASH_BASE     = 24'h100000,
    parameter int unsigned WORD_COUNT     = 1024,
    parameter int unsigned RAM_ADDR_W     = 12,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  cpu_ren,
    input  logic                  cpu_wen,
    input  logic [7:0]            cpu_address,
    input  logic [31:0]           cpu_data_in,
    output logic [31:0]           cpu_data_out,
    output logic                  cpu_stall,
    output logic                  fc_ren,
    output logic                  fc_wen,
    output logic [7:0]            fc_address,
    output logic [31:0]           fc_data_in,
    input  logic [31:0]           fc_data_out,
    output logic                  ram_we,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
`ifdef FLASH_BOOT_CHECKSUM_EN
    output logic [31:0]           checksum,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [7:0]  REG_READY      = 8'd0;
    localparam logic [7:0]  REG_READENABLE = 8'd1;
    localparam logic [7:0]  REG_ADDRESS    = 8'd4;
    localparam logic [7:0]  REG_DATAOUT    = 8'd12;
    localparam logic [31:0] READY_VALUE    = 32'hFFFF_FFFF;
    localparam logic [31:0] LAST_IDX       = WORD_COUNT - 1;
    localparam logic [31:0] SETTLE_LAST    = SETTLE_CYCLES - 1;

    typedef enum logic [3:0] {
        IDLE,
        SET_ADDR,
        SET_REN,
        SETTLE,
        POLL_REQ,
        POLL_CHK,
        READ_REQ,
        READ_CAP,
        CLR_REN,
        STORE,
        ABORT,
        DONE,
        ERROR
    } state_t;

    state_t      state;
    logic        armed;
    logic        seq_ren;
    logic        seq_wen;
    logic [7:0]  seq_address;
    logic [31:0] seq_data_in;
    logic [23:0] faddr;
    logic [31:0] word_idx;
    logic [31:0] settle_cnt;
    logic [31:0] poll_cnt;
    logic        owning;
`ifdef FLASH_BOOT_CHECKSUM_EN
    logic        sum_phase;
`endif

    // A start pulse in IDLE/DONE/ERROR claims the port in the same cycle, so a colliding CPU
    // strobe is stalled rather than forwarded.
    assign owning       = busy | start;
    assign cpu_stall    = owning;
    assign cpu_data_out = fc_data_out;
    assign fc_ren       = owning ? seq_ren     : cpu_ren;
    assign fc_wen       = owning ? seq_wen     : cpu_wen;
    assign fc_address   = owning ? seq_address : cpu_address;
    assign fc_data_in   = owning ? seq_data_in : cpu_data_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            armed       <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            seq_ren     <= 1'b0;
            seq_wen     <= 1'b0;
            seq_address <= '0;
            seq_data_in <= '0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            faddr       <= '0;
            word_idx    <= '0;
            settle_cnt  <= '0;
            poll_cnt    <= '0;
`ifdef FLASH_BOOT_CHECKSUM_EN
            checksum    <= '0;
            sum_phase   <= 1'b0;
`endif
        end else begin
            // NOTE: strobes default low every cycle and are raised only for the state being
            // entered; with non-blocking assignments the later assignment in a branch wins.
            seq_ren <= 1'b0;
            seq_wen <= 1'b0;
            ram_we  <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (armed || start) begin
                        armed    <= 1'b0;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        ram_addr <= '0;
                        word_idx <= '0;
                        faddr    <= FLASH_BASE;
`ifdef FLASH_BOOT_CHECKSUM_EN
                        checksum  <= '0;
                        sum_phase <= 1'b0;
`endif
                        if (WORD_COUNT == 0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state       <= SET_ADDR;
                            busy        <= 1'b1;
                            seq_wen     <= 1'b1;
                            seq_address <= REG_ADDRESS;
                            seq_data_in <= {8'h00, FLASH_BASE};
                        end
                    end
                end
                SET_ADDR: begin
                    state       <= SET_REN;
                    seq_wen     <= 1'b1;
                    seq_address <= REG_READENABLE;
                    seq_data_in <= 32'd1;
                end
                SET_REN: begin
                    state      <= SETTLE;
                    settle_cnt <= '0;
                    poll_cnt   <= '0;
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state       <= POLL_REQ;
                        seq_ren     <= 1'b1;
                        seq_address <= REG_READY;
                    end else begin
                        settle_cnt <= settle_cnt + 32'd1;
                    end
                end
                POLL_REQ: begin
                    state    <= POLL_CHK;
                    poll_cnt <= poll_cnt + 32'd1;
                end
                POLL_CHK: begin
                    poll_cnt <= poll_cnt + 32'd1;
                    if (fc_data_out == READY_VALUE) begin
                        state       <= READ_REQ;
                        seq_ren     <= 1'b1;
                        seq_address <= REG_DATAOUT;
                    end else if (poll_cnt + 32'd1 >= TIMEOUT_CYCLES) begin
                        // Drop READENABLE before parking in ERROR.
                        state       <= ABORT;
                        seq_wen     <= 1'b1;
                        seq_address <= REG_READENABLE;
                        seq_data_in <= 32'd0;
                    end else begin
                        state       <= POLL_REQ;
                        seq_ren     <= 1'b1;
                        seq_address <= REG_READY;
                    end
                end
                READ_REQ: begin
                    state <= READ_CAP;
                end
                READ_CAP: begin
                    state       <= CLR_REN;
                    ram_wdata   <= fc_data_out;
                    seq_wen     <= 1'b1;
                    seq_address <= REG_READENABLE;
                    seq_data_in <= 32'd0;
                end
                CLR_REN: begin
                    state  <= STORE;
`ifdef FLASH_BOOT_CHECKSUM_EN
                    ram_we <= !sum_phase;
`else
                    ram_we <= 1'b1;
`endif
                end
                STORE: begin
`ifdef FLASH_BOOT_CHECKSUM_EN
                    if (sum_phase) begin
                        state <= (ram_wdata == checksum) ? DONE : ERROR;
                        done  <= (ram_wdata == checksum);
                        error <= (ram_wdata != checksum);
                        busy  <= 1'b0;
                    end else begin
                        checksum <= checksum + ram_wdata;
                        if (word_idx == LAST_IDX) begin
                            sum_phase   <= 1'b1;
                            faddr       <= faddr + 24'd4;
                            state       <= SET_ADDR;
                            seq_wen     <= 1'b1;
                            seq_address <= REG_ADDRESS;
                            seq_data_in <= {8'h00, faddr + 24'd4};
                        end else begin
                            word_idx    <= word_idx + 32'd1;
                            ram_addr    <= ram_addr + RAM_ADDR_W'(1);
                            faddr       <= faddr + 24'd4;
                            state       <= SET_ADDR;
                            seq_wen     <= 1'b1;
                            seq_address <= REG_ADDRESS;
                            seq_data_in <= {8'h00, faddr + 24'd4};
                        end
                    end
`else
                    if (word_idx == LAST_IDX) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        word_idx    <= word_idx + 32'd1;
                        ram_addr    <= ram_addr + RAM_ADDR_W'(1);
                        faddr       <= faddr + 24'd4;
                        state       <= SET_ADDR;
                        seq_wen     <= 1'b1;
                        seq_address <= REG_ADDRESS;
                        seq_data_in <= {8'h00, faddr + 24'd4};
                    end
`endif
                end
                ABORT: begin
                    state <= ERROR;
                    error <= 1'b1;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_boot_sequencer.sv
// Self-checking bench for flash_boot_sequencer: behavioural flash-controller model, random image
// words, and a transaction-level reference of the expected copy.
`timescale 1ns/1ps
module tb_flash_boot_sequencer;

    localparam int unsigned WC     = 4;
    localparam int unsigned SETTLE = 4;
    localparam int unsigned TMO    = 100;
    localparam int unsigned AW     = 12;
    localparam logic [23:0] BASE   = 24'h100000;
`ifdef FLASH_BOOT_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam int WORD_CYCLES = 8 + SETTLE;
    localparam int COPY_EDGES  = (WC + CK) * WORD_CYCLES + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          cpu_ren = 1'b0;
    logic          cpu_wen = 1'b0;
    logic [7:0]    cpu_address = 8'h00;
    logic [31:0]   cpu_data_in = 32'h0;
    logic [31:0]   cpu_data_out;
    logic          cpu_stall;
    logic          fc_ren;
    logic          fc_wen;
    logic [7:0]    fc_address;
    logic [31:0]   fc_data_in;
    logic [31:0]   fc_data_out = 32'h0;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic          busy;
    logic          done;
    logic          error;
`ifdef FLASH_BOOT_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    always #5 clk = ~clk;

    flash_boot_sequencer #(
        .FLASH_BASE    (BASE),
        .WORD_COUNT    (WC),
        .RAM_ADDR_W    (AW),
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cpu_ren     (cpu_ren),
        .cpu_wen     (cpu_wen),
        .cpu_address (cpu_address),
        .cpu_data_in (cpu_data_in),
        .cpu_data_out(cpu_data_out),
        .cpu_stall   (cpu_stall),
        .fc_ren      (fc_ren),
        .fc_wen      (fc_wen),
        .fc_address  (fc_address),
        .fc_data_in  (fc_data_in),
        .fc_data_out (fc_data_out),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
`ifdef FLASH_BOOT_CHECKSUM_EN
        .checksum    (checksum),
`endif
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    // Flash image and controller behaviour knobs (written by the stimulus only).
    logic [31:0] image [WC];
    logic        stuck = 1'b0;
    logic        corrupt = 1'b0;
    int          hold_word = -1;
    int          hold_cycles = 0;

    // Controller state and transaction logs (written by the model only).
    logic [23:0]   fl_addr = 24'h0;
    int            countdown = 0;
    int            polls = 0;
    int            leaks = 0;
    logic [7:0]    last_wa = 8'h0;
    logic [31:0]   last_wd = 32'h0;
    logic [AW-1:0] ram_a_q [$];
    logic [31:0]   ram_d_q [$];
    logic [31:0]   faddr_q [$];

    int n_checks = 0;
    int n_fail = 0;

    function automatic logic [31:0] image_sum();
        logic [31:0] s = 32'h0;
        for (int i = 0; i < WC; i++) s = s + image[i];
        return s;
    endfunction

    function automatic logic [31:0] flash_word(input logic [23:0] a);
        int idx;
        idx = int'((a - BASE) >> 2);
        if (idx < WC) return image[idx];
        if (idx == WC) return image_sum() + {31'h0, corrupt};
        return 32'h0BAD_0BAD;
    endfunction

    always @(posedge clk) begin
        if (countdown > 0) countdown <= countdown - 1;
        if (fc_wen) begin
            last_wa <= fc_address;
            last_wd <= fc_data_in;
            if (fc_address == 8'd4) begin
                fl_addr <= fc_data_in[23:0];
                faddr_q.push_back(fc_data_in);
            end
            if (fc_address == 8'd1 && fc_data_in[0] && int'((fl_addr - BASE) >> 2) == hold_word)
                countdown <= hold_cycles;
            if (fc_address == 8'd8) leaks++;
        end
        if (fc_ren) begin
            if (fc_address == 8'd0) begin
                polls++;
                fc_data_out <= (!stuck && countdown == 0) ? 32'hFFFF_FFFF : 32'h0;
            end else if (fc_address == 8'd12) begin
                fc_data_out <= flash_word(fl_addr);
            end
        end
        if (ram_we) begin
            ram_a_q.push_back(ram_addr);
            ram_d_q.push_back(ram_wdata);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs until the sequencer settles in DONE/ERROR; edges counts clocks since the launch edge.
    task automatic wait_end(input bit poke, output int edges, output logic busy_first);
        bit fin;
        fin = 1'b0;
        edges = 0;
        busy_first = 1'b0;
        while (!fin && edges < 4000) begin
            @(negedge clk);
            edges++;
            start = 1'b0;
            if (edges == 1) begin
                #1;
                busy_first = busy;
            end
            if (poke && edges == 10) begin
                cpu_wen     = 1'b1;
                cpu_address = 8'd8;
                cpu_data_in = 32'hDEAD_BEEF;
                #1;
                check("stall_during_copy", cpu_stall, 1);
                check("no_fwd_during_copy", fc_wen && fc_address == 8'd8, 0);
            end
            if (poke && edges == 16) cpu_wen = 1'b0;
            if (!busy && (done || error)) fin = 1'b1;
        end
        if (!fin) check("copy_timeout", 0, 1);
    endtask

    task automatic verify_copy(input string tag, input int rb, input int fb);
        check({tag, "_ram_count"}, ram_d_q.size() - rb, WC);
        for (int i = 0; i < WC && rb + i < ram_d_q.size(); i++) begin
            check({tag, "_ram_addr"}, ram_a_q[rb + i], i);
            check({tag, "_ram_data"}, ram_d_q[rb + i], image[i]);
        end
        check({tag, "_faddr_count"}, faddr_q.size() - fb, WC + CK);
        for (int i = 0; i < WC + CK && fb + i < faddr_q.size(); i++)
            check({tag, "_faddr"}, faddr_q[fb + i], {8'h00, BASE + 24'(4 * i)});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   edges;
        logic bf;
        int   rb;
        int   fb;
        int   pb;
        int   lb;

        for (int i = 0; i < WC; i++) image[i] = $urandom;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_error", error, 0);
        check("reset_ram_we", ram_we, 0);
        check("reset_stall", cpu_stall, 0);
        check("reset_fc_strobes", {fc_ren, fc_wen}, 0);

        // Auto-start after reset release, READY immediate.
        rb = ram_d_q.size();
        fb = faddr_q.size();
        reset = 1'b1;
        wait_end(1'b0, edges, bf);
        check("t1_busy_first", bf, 1);
        check("t1_latency", edges, COPY_EDGES);
        check("t1_done", {done, error}, 2'b10);
        verify_copy("t1", rb, fb);
`ifdef FLASH_BOOT_CHECKSUM_EN
        check("t1_checksum", checksum, image_sum());
`endif

        // READY held low for a while on word 2.
        hold_word   = 2;
        hold_cycles = 50;
        rb = ram_d_q.size();
        fb = faddr_q.size();
        pb = polls;
        start = 1'b1;
        wait_end(1'b0, edges, bf);
        check("t2_done", {done, error}, 2'b10);
        check("t2_slower", edges > COPY_EDGES, 1);
        check("t2_extra_polls", (polls - pb) > (WC + CK), 1);
        verify_copy("t2", rb, fb);
        hold_word = -1;

        // READY stuck low -> timeout.
        stuck = 1'b1;
        rb = ram_d_q.size();
        pb = polls;
        start = 1'b1;
        wait_end(1'b0, edges, bf);
        check("t3_flags", {done, error, busy}, 3'b010);
        check("t3_last_write", {last_wa, last_wd}, {8'd1, 32'd0});
        check("t3_poll_count", polls - pb, TMO / 2);
        check("t3_no_ram", ram_d_q.size() - rb, 0);
        stuck = 1'b0;

        // CPU access during copy is stalled, forwarded once done.
        rb = ram_d_q.size();
        fb = faddr_q.size();
        lb = leaks;
        start = 1'b1;
        wait_end(1'b1, edges, bf);
        check("t4_done", {done, error}, 2'b10);
        check("t4_no_leak", leaks - lb, 0);
        verify_copy("t4", rb, fb);
        cpu_ren     = 1'b1;
        cpu_address = 8'd0;
        #1;
        check("t4_fwd_ren", {fc_ren, fc_address, cpu_stall}, {1'b1, 8'd0, 1'b0});
        @(negedge clk);
        cpu_ren = 1'b0;
        check("t4_cpu_rdata", cpu_data_out, 32'hFFFF_FFFF);

        // start and CPU write in the same DONE cycle: start wins.
        lb = leaks;
        start       = 1'b1;
        cpu_wen     = 1'b1;
        cpu_address = 8'd8;
        #1;
        check("t4_start_wins", {cpu_stall, fc_wen}, 2'b10);
        wait_end(1'b0, edges, bf);
        check("t4_held_not_fwd", leaks - lb, 0);
        #1;
        check("t4_held_fwd_after", {fc_wen, fc_address}, {1'b1, 8'd8});
        @(negedge clk);
        cpu_wen     = 1'b0;
        cpu_address = 8'd0;
        cpu_data_in = 32'h0;

        // Reset in the middle of word 2, then auto-restart from word 0.
        for (int i = 0; i < WC; i++) image[i] = $urandom;
        rb = ram_d_q.size();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2000 && (ram_d_q.size() - rb) < 2; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("t5_async_flags", {busy, done, error, cpu_stall}, 4'b0000);
        check("t5_async_strobes", {ram_we, fc_ren, fc_wen}, 3'b000);
        check("t5_async_ram", {ram_addr, ram_wdata}, 0);
        @(negedge clk);
        rb = ram_d_q.size();
        fb = faddr_q.size();
        reset = 1'b1;
        wait_end(1'b0, edges, bf);
        check("t5_latency", edges, COPY_EDGES);
        check("t5_done", {done, error}, 2'b10);
        verify_copy("t5", rb, fb);

`ifdef FLASH_BOOT_CHECKSUM_EN
        // Checksum word off by one, then correct.
        corrupt = 1'b1;
        start = 1'b1;
        wait_end(1'b0, edges, bf);
        check("t6_bad_sum", {done, error}, 2'b01);
        corrupt = 1'b0;
        start = 1'b1;
        wait_end(1'b0, edges, bf);
        check("t6_good_sum", {done, error}, 2'b10);
        check("t6_checksum", checksum, image_sum());
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
